input_sync_debounce: RTL and testbench
======================================

Name: input_sync_debounce

Overview:
- Parametrised, multi-channel input conditioner. Successor to the single-button two-flop synchroniser with falling-edge detection.
- Synchronises an external asynchronous reset. Passes NUM_INPUTS push-button inputs through SYNC_STAGES flip-flops each, then debounces each channel with a per-channel stability counter.
- Emits a debounced level plus one-cycle press and release pulses per channel.
- Sits directly behind the board pins; all downstream logic consumes only its outputs.

Parameters:
- NUM_INPUTS, 4: number of independent button channels (>= 1).
- SYNC_STAGES, 2: synchroniser flip-flops per channel (>= 2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples required before the debounced state changes (>= 1; 20 ms at 50 MHz).
- ACTIVE_LOW, 1: 1 = button inputs are inverting (pressed = 0); 0 = pressed = 1.

Ports:
- clock  in  1  50 MHz system clock.
- reset_n  in  1  Asynchronous, active-low reset (push button).
- button_in  in  NUM_INPUTS  Raw asynchronous button inputs; polarity per ACTIVE_LOW.
- reset_s2_n  out  1  Synchronised active-low reset: asserts asynchronously, deasserts synchronously.
- level  out  NUM_INPUTS  Debounced state per channel, active-high (1 = pressed).
- pressed  out  NUM_INPUTS  One-cycle pulse per channel on debounced press.
- released  out  NUM_INPUTS  One-cycle pulse per channel on debounced release.

Behaviour:
- Reset synchroniser: two flops, asynchronously cleared by reset_n low. After reset_n rises, reset_s2_n goes 1 on the 2nd rising clock edge.
- All channel logic is asynchronously reset by reset_s2_n low:
  - sync flops to the idle input level (1 if ACTIVE_LOW, else 0);
  - level = 0, counters = 0, pressed = 0, released = 0.
- Synchroniser: per channel, a shift chain of SYNC_STAGES flops. Define s[i] = last stage XOR ACTIVE_LOW, so s = 1 means pressed. A change on button_in appears on s after SYNC_STAGES rising edges.
- Debounce, per channel, evaluated at each rising edge:
  - s == level: counter <= 0.
  - s != level and counter == DEBOUNCE_CYCLES-1: level <= s, counter <= 0; pressed <= s, released <= !s.
  - s != level otherwise: counter <= counter+1.
  - pressed and released are 0 on every edge not covered by the accept case above.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Any glitch that returns s to level clears the counter. The full DEBOUNCE_CYCLES run restarts.
- Latency: a clean input change reaches level, and the matching pulse, SYNC_STAGES + DEBOUNCE_CYCLES rising edges after first being sampled. The pulse is high for exactly the cycle in which level first shows the new value.
- pressed and released are mutually exclusive per channel and registered. Each pulse is exactly 1 clock wide.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.
- Reset mid-operation: counters and pulses clear immediately; no pulse is emitted during or due to reset.
- An input held pressed through reset release is treated as a new press. One pressed pulse follows after SYNC_STAGES + DEBOUNCE_CYCLES edges from reset_s2_n rising.
- DEBOUNCE_CYCLES = 1: level follows s one edge later; no filtering.

Test Plan (NUM_INPUTS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset: drive reset_n low between edges -> reset_s2_n and all outputs 0 with no clock edge. Release -> reset_s2_n = 1 after the 2nd edge; level = 0, no pulses.
- Clean press: button_in[0] 1->0 before edge E -> level[0] = 1 and pressed[0] = 1 after edge E+5 (6th edge). pressed[0] = 0 after E+6. Other channels stay 0.
- Bounce rejection: button_in[1] low for 3 cycles, high 1, low 3, high -> no pulse, level[1] = 0. Then hold low >= 6 cycles -> exactly one pressed[1] pulse.
- Release: from level[0] = 1, button_in[0] 0->1 -> released[0] single pulse and level[0] = 0 on the 6th edge; pressed[0] stays 0.
- Simultaneous: ch0 and ch3 pressed while ch2 released in the same cycle -> pressed = 4'b1001 and released = 4'b0100 on the same cycle.
- Reset mid-debounce: after ch1 has counted 2 cycles, pulse reset_n low -> no pulse, counter cleared. With ch1 held low, pressed[1] fires 6 edges after reset_s2_n rises.

Source files
------------

// File: rtl/input_sync_debounce.sv
// Multi-channel push-button conditioner.
//
// Synchronises the external reset (asynchronous assert, synchronous release), passes each
// button through a SYNC_STAGES flop chain, then debounces every channel with its own
// stability counter. Each channel produces a debounced level plus one-cycle press and
// release pulses.
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset from the board
//   button_in   raw asynchronous buttons, pressed = 0 when ACTIVE_LOW, else pressed = 1
//   reset_s2_n  synchronised active-low reset for downstream logic
//   level       debounced state per channel, 1 = pressed
//   pressed     one-cycle pulse on a debounced press
//   released    one-cycle pulse on a debounced release
module input_sync_debounce #(
  parameter int unsigned NUM_INPUTS      = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] button_in,
  output logic                  reset_s2_n,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] pressed,
  output logic [NUM_INPUTS-1:0] released
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  // Idle (released) value of the raw pin, used to preload the synchroniser.
  localparam logic [SYNC_STAGES-1:0] SyncIdle = {SYNC_STAGES{ACTIVE_LOW}};

  // ---------------------------------------------------------------------------
  // Reset synchroniser
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign reset_s2_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser and debounce state
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q [NUM_INPUTS];
  logic [CntW-1:0]        cnt_q  [NUM_INPUTS];
  logic [CntW-1:0]        cnt_d  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  level_q, level_d;
  logic [NUM_INPUTS-1:0]  pressed_q, pressed_d;
  logic [NUM_INPUTS-1:0]  released_q, released_d;
  logic [NUM_INPUTS-1:0]  s;

  always_comb begin
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    s          = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      // Normalise polarity so that s = 1 means the button is pressed.
      s[i] = sync_q[i][SYNC_STAGES-1] ^ ACTIVE_LOW;
      if (s[i] == level_q[i]) begin
        // Any sample agreeing with the current level restarts the stability run.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i]    = s[i];
        cnt_d[i]      = '0;
        pressed_d[i]  = s[i];
        released_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        sync_q[i] <= SyncIdle;
        cnt_q[i]  <= '0;
      end
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], button_in[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign level    = level_q;
  assign pressed  = pressed_q;
  assign released = released_q;

endmodule

// File: tb/tb_input_sync_debounce.sv
// Scoreboard bench for input_sync_debounce (4 channels, 2 sync stages, 4 debounce cycles,
// active-low buttons). A reference model pushes the expected outputs for every clock edge;
// a monitor pops and compares them 1 time unit after the edge. Directed checks cover the
// reset sequence, latency and pulse placement.
module tb_input_sync_debounce;

  localparam int unsigned NI = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam bit          AL = 1'b1;

  typedef logic [3*NI:0] obs_t;

  logic          clock;
  logic          reset_n;
  logic [NI-1:0] button_in;
  logic          reset_s2_n;
  logic [NI-1:0] level;
  logic [NI-1:0] pressed;
  logic [NI-1:0] released;

  int checks = 0;
  int errors = 0;

  input_sync_debounce #(
    .NUM_INPUTS     (NI),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .button_in (button_in),
    .reset_s2_n(reset_s2_n),
    .level     (level),
    .pressed   (pressed),
    .released  (released)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic nedges(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the debouncer sees the pressed-state of the pin as captured SS edges
  // earlier (idle before that), and the level flips once the last DC seen samples all
  // disagree with it. The reset synchroniser releases after two edges with reset_n high.
  // ---------------------------------------------------------------------------
  obs_t exp_q[$];
  int   rcnt = 0;
  bit   samp_q [NI][$];
  bit   win_q  [NI][$];
  bit   m_lvl  [NI];

  always @(posedge clock) begin : model
    logic [NI-1:0] pr, rl, lv;
    bit            sv;
    int            ndiff;
    pr = '0;
    rl = '0;
    if (!reset_n) begin
      rcnt = 0;
      for (int c = 0; c < NI; c++) begin
        samp_q[c].delete();
        win_q[c].delete();
        m_lvl[c] = 1'b0;
      end
    end else begin
      if (rcnt >= 2) begin
        for (int c = 0; c < NI; c++) begin
          samp_q[c].push_back(button_in[c] ^ AL);
          sv = 1'b0;
          if (samp_q[c].size() > SS) sv = samp_q[c].pop_front();
          win_q[c].push_back(sv);
          if (win_q[c].size() > DC) void'(win_q[c].pop_front());
          ndiff = 0;
          for (int j = 0; j < win_q[c].size(); j++) begin
            if (win_q[c][j] != m_lvl[c]) ndiff++;
          end
          if (ndiff == DC) begin
            m_lvl[c] = sv;
            pr[c]    = sv;
            rl[c]    = ~sv;
          end
        end
      end
      if (rcnt < 2) rcnt++;
    end
    for (int c = 0; c < NI; c++) lv[c] = m_lvl[c];
    exp_q.push_back({(rcnt >= 2), lv, pr, rl});
  end

  always @(posedge clock) begin : monitor
    obs_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard{rst_s2,level,pressed,released}",
            32'({reset_s2_n, level, pressed, released}), 32'(e));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int hold [NI];

  initial begin
    button_in = '1;
    reset_n   = 1'b1;
    #5;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({reset_s2_n, level, pressed, released}), 32'd0);
    nedges(2);
    reset_n = 1'b1;
    nedges(1);
    check("rst_s2_after_edge1", 32'(reset_s2_n), 32'd0);
    nedges(1);
    check("rst_s2_after_edge2", 32'(reset_s2_n), 32'd1);
    check("post_reset_state", 32'({level, pressed, released}), 32'd0);

    // Clean press on ch0: visible after the 6th edge.
    button_in[0] = 1'b0;
    nedges(5);
    check("press_not_yet", 32'({level, pressed}), 32'd0);
    nedges(1);
    check("press_6th_edge", 32'({level, pressed, released}), 32'({4'b0001, 4'b0001, 4'b0000}));
    nedges(1);
    check("press_pulse_ends", 32'({level, pressed}), 32'({4'b0001, 4'b0000}));

    // Release ch0.
    button_in[0] = 1'b1;
    nedges(5);
    check("release_not_yet", 32'({level, released}), 32'({4'b0001, 4'b0000}));
    nedges(1);
    check("release_6th_edge", 32'({level, pressed, released}), 32'({4'b0000, 4'b0000, 4'b0001}));

    // Bounce on ch1: runs of 3 are too short.
    button_in[1] = 1'b0;
    nedges(3);
    button_in[1] = 1'b1;
    nedges(1);
    button_in[1] = 1'b0;
    nedges(3);
    button_in[1] = 1'b1;
    nedges(8);
    check("bounce_rejected", 32'(level), 32'd0);
    button_in[1] = 1'b0;
    nedges(6);
    check("bounce_then_hold", 32'({level, pressed}), 32'({4'b0010, 4'b0010}));
    button_in[1] = 1'b1;
    nedges(8);

    // Simultaneous: ch2 pressed first, then ch0/ch3 pressed while ch2 released.
    button_in[2] = 1'b0;
    nedges(8);
    check("ch2_held", 32'(level), 32'b0100);
    button_in = 4'b0110;
    nedges(5);
    check("simul_not_yet", 32'({pressed, released}), 32'd0);
    nedges(1);
    check("simul_pulses", 32'({level, pressed, released}), 32'({4'b1001, 4'b1001, 4'b0100}));

    // Reset mid-debounce: ch1 has counted two samples, ch0/ch3 still held.
    button_in = 4'b0100;
    nedges(4);
    reset_n = 1'b0;
    #1;
    check("midop_async_clear", 32'({reset_s2_n, level, pressed, released}), 32'd0);
    nedges(1);
    reset_n = 1'b1;
    nedges(7);
    check("held_through_reset_wait", 32'({level, pressed}), 32'd0);
    nedges(1);
    check("held_through_reset_press", 32'({level, pressed}), 32'({4'b1011, 4'b1011}));

    // Randomised bouncing with occasional resets, checked by the scoreboard.
    for (int c = 0; c < NI; c++) hold[c] = $urandom_range(1, 9);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      for (int c = 0; c < NI; c++) begin
        if (hold[c] == 0) begin
          button_in[c] = ~button_in[c];
          hold[c]      = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        nedges($urandom_range(1, 2));
        reset_n = 1'b1;
      end
    end

    nedges(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
